// File: rtl/ctrl_fsm.sv
// ctrl_fsm: instruction-sequencing controller for the 8-bit processor.
// It fetches 1- and 2-byte instructions from synchronous program memory.
// It is the only driver of the pc block controls (cnt/ld/addr).
// It holds the instruction register (ir) and the immediate register (imm).
// It issues one-cycle strobes to the ALU and to the accumulator write path.
// Optional feature: define CTRL_TRAP_EN to add the illegal-opcode trap.
//   - Illegal opcodes then jump to 8'hF0 and pulse trap.
//   - Without it, illegal opcodes behave as NOP and trap is tied to 0.
//
// Handshake/strobe semantics: there is no valid/ready pair here.
//   - Every strobe (mem_rd, pc_cnt, pc_ld, alu_en, imm_ld, trap) is a
//     single-cycle, state-decoded level.
//   - A strobe is acted on at the rising edge that ends the cycle in which
//     it is high.
//   - mem_data is consumed exactly one cycle after the mem_rd that
//     requested it.
//   - pc_cnt and pc_ld are mutually exclusive by construction.
//   - All strobes are forced low while rst is high.
// dbg_state exposes the FSM state for checkers.
module ctrl_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] mem_data,
  input  logic       zero,
  output logic       mem_rd,
  output logic       pc_cnt,
  output logic       pc_ld,
  output logic [7:0] pc_addr,
  output logic [7:0] ir,
  output logic [7:0] imm,
  output logic       alu_en,
  output logic [3:0] alu_op,
  output logic       imm_ld,
  output logic       halted,
  output logic       trap,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_IR_LOAD = 3'd1,
    S_DECODE  = 3'd2,
    S_OP_LOAD = 3'd3,
    S_EXEC    = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ALU = 4'h1;
  localparam logic [3:0] OP_LDI = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h3;
  localparam logic [3:0] OP_JZ  = 4'h4;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_ir;
  logic [7:0] r_imm;
  logic [3:0] w_opc;
  logic       w_rd;
  logic       w_cnt;
  logic       w_ld;
  logic       w_alu;
  logic       w_imm_ld;
`ifdef CTRL_TRAP_EN
  logic       w_trap;
`endif

  assign w_opc = r_ir[7:4];

  // State register; asynchronous reset returns to FETCH from any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Instruction and operand capture, one cycle after the matching mem_rd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir  <= 8'h00;
      r_imm <= 8'h00;
    end else begin
      if (r_state == S_IR_LOAD) r_ir  <= mem_data;
      if (r_state == S_OP_LOAD) r_imm <= mem_data;
    end
  end

  // Next-state and Moore strobe decode.
  always_comb begin
    w_next   = r_state;
    w_rd     = 1'b0;
    w_cnt    = 1'b0;
    w_ld     = 1'b0;
    w_alu    = 1'b0;
    w_imm_ld = 1'b0;
`ifdef CTRL_TRAP_EN
    w_trap   = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        if (run) begin
          w_rd   = 1'b1;
          w_cnt  = 1'b1;
          w_next = S_IR_LOAD;
        end
      end
      S_IR_LOAD: w_next = S_DECODE;
      S_DECODE: begin
        case (w_opc)
          OP_NOP: w_next = S_FETCH;
          OP_ALU: begin
            w_alu  = 1'b1;
            w_next = S_FETCH;
          end
          OP_LDI, OP_JMP, OP_JZ: begin
            // Operand fetch: PC already points at the second byte.
            w_rd   = 1'b1;
            w_cnt  = 1'b1;
            w_next = S_OP_LOAD;
          end
          OP_HLT: w_next = S_HALT;
          default: begin
            w_next = S_FETCH;
`ifdef CTRL_TRAP_EN
            w_ld   = 1'b1;
            w_trap = 1'b1;
`endif
          end
        endcase
      end
      S_OP_LOAD: w_next = S_EXEC;
      S_EXEC: begin
        w_next = S_FETCH;
        case (w_opc)
          OP_LDI:  w_imm_ld = 1'b1;
          OP_JMP:  w_ld     = 1'b1;
          // Not taken: PC already sits past the operand, nothing to do.
          OP_JZ:   w_ld     = zero;
          default: w_ld     = 1'b0;
        endcase
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  assign mem_rd    = w_rd     & ~rst;
  assign pc_cnt    = w_cnt    & ~rst;
  assign pc_ld     = w_ld     & ~rst;
  assign alu_en    = w_alu    & ~rst;
  assign imm_ld    = w_imm_ld & ~rst;
  assign halted    = (r_state == S_HALT) & ~rst;
  assign ir        = r_ir;
  assign imm       = r_imm;
  assign alu_op    = r_ir[3:0];
  assign dbg_state = r_state;

`ifdef CTRL_TRAP_EN
  assign trap    = w_trap & ~rst;
  assign pc_addr = w_trap ? 8'hF0 : r_imm;
`else
  assign trap    = 1'b0;
  assign pc_addr = r_imm;
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// Testbench for ctrl_fsm.
// It models the pc block and the synchronous program memory around the DUT.
// It compares the DUT against directed scenarios and against an
// instruction-level reference model of random programs.
module tb_ctrl_fsm;

  logic       clk;
  logic       rst;
  logic       run;
  logic [7:0] mem_data;
  logic       zero;
  logic       mem_rd;
  logic       pc_cnt;
  logic       pc_ld;
  logic [7:0] pc_addr;
  logic [7:0] ir;
  logic [7:0] imm;
  logic       alu_en;
  logic [3:0] alu_op;
  logic       imm_ld;
  logic       halted;
  logic       trap;
  logic [2:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  ctrl_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .mem_data  (mem_data),
    .zero      (zero),
    .mem_rd    (mem_rd),
    .pc_cnt    (pc_cnt),
    .pc_ld     (pc_ld),
    .pc_addr   (pc_addr),
    .ir        (ir),
    .imm       (imm),
    .alu_en    (alu_en),
    .alu_op    (alu_op),
    .imm_ld    (imm_ld),
    .halted    (halted),
    .trap      (trap),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Environment: pc block (cnt has priority) and synchronous program memory
  // ---------------------------------------------------------------------------
  logic [7:0] mem [256];
  logic [7:0] tb_pc;

  always @(posedge clk or posedge rst) begin
    if (rst)         tb_pc <= 8'h00;
    else if (pc_cnt) tb_pc <= tb_pc + 8'h01;
    else if (pc_ld)  tb_pc <= pc_addr;
  end

  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem[tb_pc];
  end

  // ---------------------------------------------------------------------------
  // Observation log (sampled on the falling edge, away from the active edge)
  // ---------------------------------------------------------------------------
  logic       log_clr;
  logic [7:0] rd_log[$];
  int         rd_cyc[$];
  logic [3:0] alu_log[$];
  logic [7:0] imm_log[$];
  logic [7:0] ld_log[$];
  int         trap_cnt;
  int         cnt_cnt;
  int         overlap_cnt;
  int         cyc;

  always @(negedge clk) begin
    if (log_clr) begin
      rd_log.delete();
      rd_cyc.delete();
      alu_log.delete();
      imm_log.delete();
      ld_log.delete();
      trap_cnt    <= 0;
      cnt_cnt     <= 0;
      overlap_cnt <= 0;
      cyc         <= 0;
    end else if (!rst) begin
      if (mem_rd) begin
        rd_log.push_back(tb_pc);
        rd_cyc.push_back(cyc);
      end
      if (alu_en) alu_log.push_back(alu_op);
      if (imm_ld) imm_log.push_back(imm);
      if (pc_ld)  ld_log.push_back(pc_addr);
      if (trap)   trap_cnt <= trap_cnt + 1;
      if (pc_cnt) cnt_cnt <= cnt_cnt + 1;
      if (pc_cnt && pc_ld) overlap_cnt <= overlap_cnt + 1;
      cyc <= cyc + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    run     = 1'b0;
    rst     = 1'b1;
    log_clr = 1'b1;
    tick();
    tick();
    rst     = 1'b0;
    log_clr = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: instruction-level interpreter.
  // It fills the expected queues with what the controller must emit.
  // ---------------------------------------------------------------------------
  logic [7:0] exp_rd_q[$];
  int         exp_cyc_q[$];
  logic [3:0] exp_alu_q[$];
  logic [7:0] exp_imm_q[$];
  logic [7:0] exp_ld_q[$];

  task automatic model_program(input int n_instr, input logic z,
                               output int t_cyc, output int n_trap,
                               output bit halt);
    logic [7:0] pc;
    logic [7:0] op;
    logic [7:0] opnd;
    exp_rd_q.delete();
    exp_cyc_q.delete();
    exp_alu_q.delete();
    exp_imm_q.delete();
    exp_ld_q.delete();
    pc     = 8'h00;
    t_cyc  = 0;
    n_trap = 0;
    halt   = 1'b0;
    for (int i = 0; i < n_instr; i++) begin
      op = mem[pc];
      exp_rd_q.push_back(pc);
      exp_cyc_q.push_back(t_cyc);
      pc = pc + 8'h01;
      case (op[7:4])
        4'h0: t_cyc += 3;
        4'h1: begin
          exp_alu_q.push_back(op[3:0]);
          t_cyc += 3;
        end
        4'h2, 4'h3, 4'h4: begin
          opnd = mem[pc];
          exp_rd_q.push_back(pc);
          exp_cyc_q.push_back(t_cyc + 2);
          pc = pc + 8'h01;
          t_cyc += 5;
          if (op[7:4] == 4'h2) exp_imm_q.push_back(opnd);
          if (op[7:4] == 4'h3 || (op[7:4] == 4'h4 && z)) begin
            exp_ld_q.push_back(opnd);
            pc = opnd;
          end
        end
        4'hF: begin
          t_cyc += 3;
          halt = 1'b1;
          break;
        end
        default: begin
          t_cyc += 3;
`ifdef CTRL_TRAP_EN
          exp_ld_q.push_back(8'hF0);
          n_trap++;
          pc = 8'hF0;
`endif
        end
      endcase
    end
  endtask

  function automatic logic [7:0] gen_byte();
    int r;
    logic [3:0] hi;
    r = $urandom_range(0, 19);
    if (r < 3)       hi = 4'h0;
    else if (r < 8)  hi = 4'h1;
    else if (r < 11) hi = 4'h2;
    else if (r < 14) hi = 4'h3;
    else if (r < 17) hi = 4'h4;
    else if (r < 18) hi = 4'hF;
    else             hi = 4'($urandom_range(5, 14));
    return {hi, 4'($urandom_range(0, 15))};
  endfunction

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; run = 1'b1; zero = 1'b0; log_clr = 1'b1;
    tick();
    n_tests++;
    if ({mem_rd, pc_cnt, pc_ld, alu_en, imm_ld, halted, trap} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want 0000000",
               {mem_rd, pc_cnt, pc_ld, alu_en, imm_ld, halted, trap});
    end
    n_tests++;
    if ({ir, imm, pc_addr} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_regs: ir/imm/pc_addr got %h want 000000", {ir, imm, pc_addr});
    end
    n_tests++;
    if (dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want 0 (FETCH)", dbg_state);
    end
    run = 1'b0;
  endtask

  task automatic test_rst_in_flight();
    clear_mem();
    mem[0] = 8'h20; mem[1] = 8'h55;
    do_reset();
    run = 1'b1;
    repeat (4) tick();
    n_tests++;
    if (imm_ld !== 1'b1 || imm !== 8'h55) begin
      n_fail++;
      $display("FAIL inflight_exec: imm_ld=%b imm=%h want 1/55", imm_ld, imm);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (imm_ld !== 1'b0 || imm !== 8'h00 || dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL inflight_rst: imm_ld=%b imm=%h state=%0d want 0/00/0",
               imm_ld, imm, dbg_state);
    end
    do_reset();
  endtask

  task automatic test_nop_alu();
    logic exp_cnt;
    logic exp_alu;
    clear_mem();
    mem[0] = 8'h00; mem[1] = 8'h15;
    do_reset();
    run = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_cnt = (k == 0 || k == 3);
      exp_alu = (k == 5);
      n_tests++;
      if (pc_cnt !== exp_cnt || mem_rd !== exp_cnt) begin
        n_fail++;
        $display("FAIL nop_alu_cnt cycle %0d: pc_cnt=%b mem_rd=%b want %b",
                 k, pc_cnt, mem_rd, exp_cnt);
      end
      n_tests++;
      if (alu_en !== exp_alu) begin
        n_fail++;
        $display("FAIL nop_alu_en cycle %0d: got %b want %b", k, alu_en, exp_alu);
      end
      if (k == 5) begin
        n_tests++;
        if (alu_op !== 4'h5) begin
          n_fail++;
          $display("FAIL nop_alu_op: got %h want 5", alu_op);
        end
        run = 1'b0;
      end
      tick();
    end
    n_tests++;
    if (ir !== 8'h15) begin
      n_fail++;
      $display("FAIL nop_alu_ir: got %h want 15", ir);
    end
  endtask

  task automatic test_ldi();
    logic [7:0] want [5];
    want = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h12};
    clear_mem();
    mem[0] = 8'h30; mem[1] = 8'h10; mem[8'h10] = 8'h20; mem[8'h11] = 8'hA7;
    do_reset();
    run = 1'b1;
    repeat (16) tick();
    run = 1'b0;
    n_tests++;
    if (rd_log.size() < 5) begin
      n_fail++;
      $display("FAIL ldi_rd_count: got %0d want >=5", rd_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (rd_log[i] !== want[i]) begin
          n_fail++;
          $display("FAIL ldi_rd[%0d]: got %h want %h", i, rd_log[i], want[i]);
        end
      end
    end
    n_tests++;
    if (imm_log.size() != 1 || imm !== 8'hA7) begin
      n_fail++;
      $display("FAIL ldi_imm: imm_ld pulses=%0d imm=%h want 1/a7", imm_log.size(), imm);
    end else if (imm_log[0] !== 8'hA7) begin
      n_fail++;
      $display("FAIL ldi_imm_val: got %h want a7", imm_log[0]);
    end
  endtask

  task automatic test_jmp();
    clear_mem();
    mem[0] = 8'h30; mem[1] = 8'h20; mem[8'h20] = 8'h30; mem[8'h21] = 8'h80;
    do_reset();
    run = 1'b1;
    repeat (12) tick();
    run = 1'b0;
    n_tests++;
    if (ld_log.size() != 2) begin
      n_fail++;
      $display("FAIL jmp_ld_count: got %0d want 2", ld_log.size());
    end else if (ld_log[1] !== 8'h80) begin
      n_fail++;
      $display("FAIL jmp_pc_addr: got %h want 80", ld_log[1]);
    end
    n_tests++;
    if (rd_log.size() < 5) begin
      n_fail++;
      $display("FAIL jmp_rd_count: got %0d want >=5", rd_log.size());
    end else if (rd_log[4] !== 8'h80) begin
      n_fail++;
      $display("FAIL jmp_next_fetch: got %h want 80", rd_log[4]);
    end
    n_tests++;
    if (overlap_cnt != 0) begin
      n_fail++;
      $display("FAIL jmp_cnt_ld_overlap: got %0d want 0", overlap_cnt);
    end
  endtask

  task automatic test_jz(input logic z);
    logic [7:0] want_pc;
    want_pc = z ? 8'h90 : 8'h42;
    clear_mem();
    mem[0] = 8'h30; mem[1] = 8'h40; mem[8'h40] = 8'h40; mem[8'h41] = 8'h90;
    do_reset();
    zero = z;
    run  = 1'b1;
    repeat (12) tick();
    run  = 1'b0;
    n_tests++;
    if (rd_log.size() < 5) begin
      n_fail++;
      $display("FAIL jz%0d_rd_count: got %0d want >=5", z, rd_log.size());
    end else if (rd_log[4] !== want_pc) begin
      n_fail++;
      $display("FAIL jz%0d_next_fetch: got %h want %h", z, rd_log[4], want_pc);
    end
    n_tests++;
    if (ld_log.size() != (z ? 2 : 1)) begin
      n_fail++;
      $display("FAIL jz%0d_ld_count: got %0d want %0d", z, ld_log.size(), z ? 2 : 1);
    end
    zero = 1'b0;
  endtask

  task automatic test_illegal();
    clear_mem();
    mem[0] = 8'h73;
    do_reset();
    run = 1'b1;
    repeat (5) tick();
    run = 1'b0;
    n_tests++;
    if (rd_log.size() < 2) begin
      n_fail++;
      $display("FAIL illegal_rd_count: got %0d want >=2", rd_log.size());
    end else begin
`ifdef CTRL_TRAP_EN
      if (rd_log[1] !== 8'hF0 || trap_cnt != 1) begin
        n_fail++;
        $display("FAIL illegal_trap: next fetch %h traps %0d want f0/1", rd_log[1], trap_cnt);
      end
`else
      if (rd_log[1] !== 8'h01 || trap_cnt != 0 || ld_log.size() != 0) begin
        n_fail++;
        $display("FAIL illegal_nop: next fetch %h traps %0d loads %0d want 01/0/0",
                 rd_log[1], trap_cnt, ld_log.size());
      end
`endif
    end
  endtask

  task automatic test_halt();
    clear_mem();
    mem[0] = 8'hF0;
    do_reset();
    run = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 20; k++) begin
      run = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_tests++;
      if (halted !== 1'b1 || mem_rd !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_hold cycle %0d: halted=%b mem_rd=%b want 1/0", k, halted, mem_rd);
      end
      tick();
    end
    n_tests++;
    if (rd_log.size() != 1) begin
      n_fail++;
      $display("FAIL halt_rd_count: got %0d want 1", rd_log.size());
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (halted !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_rst: halted got %b want 0", halted);
    end
    do_reset();
    run = 1'b1;
    repeat (2) tick();
    run = 1'b0;
    n_tests++;
    if (rd_log.size() < 1) begin
      n_fail++;
      $display("FAIL halt_resume: no fetch after reset");
    end else if (rd_log[0] !== 8'h00) begin
      n_fail++;
      $display("FAIL halt_resume: fetch from %h want 00", rd_log[0]);
    end
  endtask

  task automatic test_random(input int n_prog);
    int   t_cyc;
    int   n_trap;
    bit   halt;
    logic z;
    for (int p = 0; p < n_prog; p++) begin
      for (int i = 0; i < 256; i++) mem[i] = gen_byte();
      z = 1'($urandom_range(0, 1));
      model_program(40, z, t_cyc, n_trap, halt);
      do_reset();
      zero = z;
      run  = 1'b1;
      repeat (t_cyc) tick();
      if (!halt) run = 1'b0;
      repeat (4) tick();
      run = 1'b0;
      n_tests++;
      if (rd_log.size() != exp_rd_q.size() || cnt_cnt != exp_rd_q.size()) begin
        n_fail++;
        $display("FAIL rand%0d_rd_count: mem_rd %0d pc_cnt %0d want %0d",
                 p, rd_log.size(), cnt_cnt, exp_rd_q.size());
      end
      for (int i = 0; i < exp_rd_q.size() && i < rd_log.size(); i++) begin
        n_tests++;
        if (rd_log[i] !== exp_rd_q[i] || rd_cyc[i] != exp_cyc_q[i]) begin
          n_fail++;
          $display("FAIL rand%0d_rd[%0d]: addr %h cycle %0d want %h cycle %0d",
                   p, i, rd_log[i], rd_cyc[i], exp_rd_q[i], exp_cyc_q[i]);
          break;
        end
      end
      n_tests++;
      if (alu_log != exp_alu_q) begin
        n_fail++;
        $display("FAIL rand%0d_alu: got %0d ops want %0d", p, alu_log.size(), exp_alu_q.size());
      end
      n_tests++;
      if (imm_log != exp_imm_q) begin
        n_fail++;
        $display("FAIL rand%0d_imm_ld: got %0d writes want %0d", p, imm_log.size(), exp_imm_q.size());
      end
      n_tests++;
      if (ld_log != exp_ld_q) begin
        n_fail++;
        $display("FAIL rand%0d_pc_ld: got %0d loads want %0d", p, ld_log.size(), exp_ld_q.size());
      end
      n_tests++;
      if (trap_cnt != n_trap || overlap_cnt != 0 || halted !== halt) begin
        n_fail++;
        $display("FAIL rand%0d_misc: traps %0d overlap %0d halted %b want %0d/0/%b",
                 p, trap_cnt, overlap_cnt, halted, n_trap, halt);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; run = 1'b0; zero = 1'b0; log_clr = 1'b1;
    clear_mem();
    test_reset();
    test_rst_in_flight();
    test_nop_alu();
    test_ldi();
    test_jmp();
    test_jz(1'b0);
    test_jz(1'b1);
    test_illegal();
    test_halt();
    test_random(12);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
